// File: rtl/apb_pkg.sv
// Shared types and constants for the core-to-APB bridge.
package apb_pkg;

    localparam int unsigned NUM_SLAVES = 4;

    localparam logic [19:0] SLV0_BASE = 20'h10000;
    localparam logic [19:0] SLV1_BASE = 20'h10001;
    localparam logic [19:0] SLV2_BASE = 20'h10002;
    localparam logic [19:0] SLV3_BASE = 20'h10003;

    localparam logic [31:0] ERR_TIMEOUT_DATA  = 32'hDEAD_BEEF;
    localparam logic [31:0] ERR_UNMAPPED_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the 4 KiB page of a bus address onto a one-hot APB slave select.
module apb_addr_decoder
    import apb_pkg::*;
(
    input  logic [19:0]           page_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  mapped_o
);

    always_comb begin
        sel_o = '0;
        case (page_i)
            SLV0_BASE: sel_o = 4'b0001;
            SLV1_BASE: sel_o = 4'b0010;
            SLV2_BASE: sel_o = 4'b0100;
            SLV3_BASE: sel_o = 4'b1000;
            default:   sel_o = '0;
        endcase
        mapped_o = |sel_o;
    end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding bridge from the core data bus to APB4, with wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     transfer,
    input  logic                     busWe,
    input  logic [31:0]              busAddr,
    input  logic [31:0]              busWData,
    input  logic [3:0]               Byte_Enable,
    output logic [31:0]              busRData,
    output logic                     ready,
    output logic                     busErr,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic [3:0]               PSTRB,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [NUM_SLAVES*32-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);

    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

    state_e                  state_q;
    logic [31:0]             paddr_q, pwdata_q, rdata_q;
    logic                    pwrite_q, penable_q, ready_q, err_q;
    logic [3:0]              pstrb_q;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic [15:0]             wait_cnt_q;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_mapped;
    logic                    slv_ready;
    logic [31:0]             slv_rdata;

    apb_addr_decoder u_dec (
        .page_i   (busAddr[31:12]),
        .sel_o    (dec_sel),
        .mapped_o (dec_mapped)
    );

    // Only the selected slave's handshake is looked at; the rest are don't-care.
    always_comb begin
        slv_ready = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_q[i]) begin
                slv_ready = PREADY[i];
                slv_rdata = PRDATA[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            pstrb_q    <= '0;
            psel_q     <= '0;
            penable_q  <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (transfer) begin
                        paddr_q  <= busAddr;
                        pwrite_q <= busWe;
                        pwdata_q <= busWData;
                        pstrb_q  <= busWe ? Byte_Enable : 4'b0000;
                        if (dec_mapped) begin
                            psel_q  <= dec_sel;
                            state_q <= StSetup;
                        end else begin
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            if (!busWe) rdata_q <= ERR_UNMAPPED_DATA;
                            state_q <= StDone;
                        end
                    end
                end
                StSetup: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= StAccess;
                end
                StAccess: begin
                    if (slv_ready) begin
                        if (!pwrite_q) rdata_q <= slv_rdata;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                        if (wait_cnt_q + 16'd1 == TimeoutCnt) begin
                            if (!pwrite_q) rdata_q <= ERR_TIMEOUT_DATA;
                            psel_q    <= '0;
                            penable_q <= 1'b0;
                            ready_q   <= 1'b1;
                            err_q     <= 1'b1;
                            state_q   <= StDone;
                        end
                    end
                end
                StDone: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busRData = rdata_q;
    assign ready    = ready_q;
    assign busErr   = err_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign PWRITE   = pwrite_q;
    assign PSTRB    = pstrb_q;
    assign PENABLE  = penable_q;
    assign PSEL     = psel_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table plus reset and transfer-glitch sequences.
module tb_apb_master;

    logic         clk = 1'b0;
    logic         reset;
    logic         transfer;
    logic         busWe;
    logic [31:0]  busAddr;
    logic [31:0]  busWData;
    logic [3:0]   Byte_Enable;
    logic [31:0]  busRData;
    logic         ready;
    logic         busErr;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic         PWRITE;
    logic [3:0]   PSTRB;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apb_master #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .transfer    (transfer),
        .busWe       (busWe),
        .busAddr     (busAddr),
        .busWData    (busWData),
        .Byte_Enable (Byte_Enable),
        .busRData    (busRData),
        .ready       (ready),
        .busErr      (busErr),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSTRB       (PSTRB),
        .PENABLE     (PENABLE),
        .PSEL        (PSEL),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          slave;
        int          waits;
        logic [31:0] rdata_in;
        logic        poke;
        logic [3:0]  exp_psel;
        logic [3:0]  exp_pstrb;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t        v;
        int          lat, acc, setup_cnt, paddr_bad, trail;
        logic [3:0]  psel_or, pstrb1;
        logic        pwrite1;
        logic [31:0] paddr1, pwdata1;
        v = vecs[idx];
        lat = 0; acc = 0; setup_cnt = 0; paddr_bad = 0; trail = 0;
        psel_or = '0; pstrb1 = '0; pwrite1 = 1'b0; paddr1 = '0; pwdata1 = '0;

        @(negedge clk);
        for (int s = 0; s < 4; s++) PRDATA[s*32 +: 32] = 32'hBAD0_0000 | 32'(s);
        PRDATA[v.slave*32 +: 32] = v.rdata_in;
        PREADY      = ~(4'b0001 << v.slave);
        transfer    = 1'b1;
        busWe       = v.we;
        busAddr     = v.addr;
        busWData    = v.wdata;
        Byte_Enable = v.be;

        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                pstrb1  = PSTRB;
                pwrite1 = PWRITE;
                paddr1  = PADDR;
                pwdata1 = PWDATA;
            end
            psel_or |= PSEL;
            if (PSEL != 4'b0 && PADDR != v.addr) paddr_bad++;
            if (PSEL != 4'b0 && !PENABLE) setup_cnt++;
            if (PSEL != 4'b0 && PENABLE) acc++;
            transfer = v.poke && acc == 2;
            busAddr  = (v.poke && acc == 2) ? 32'h1000_2000 : v.addr;
            busWe    = (v.poke && acc == 2) ? ~v.we : v.we;
            PREADY[v.slave] = (acc > v.waits);
        end while (!ready && lat < 100);

        check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d busErr", idx), {31'b0, busErr}, {31'b0, v.exp_err});
        check($sformatf("v%0d busRData", idx), busRData, v.exp_rdata);
        check($sformatf("v%0d psel_seen", idx), {28'b0, psel_or}, {28'b0, v.exp_psel});
        check($sformatf("v%0d PSTRB", idx), {28'b0, pstrb1}, {28'b0, v.exp_pstrb});
        check($sformatf("v%0d PWRITE", idx), {31'b0, pwrite1}, {31'b0, v.we});
        check($sformatf("v%0d PADDR", idx), paddr1, v.addr);
        check($sformatf("v%0d PWDATA", idx), pwdata1, v.wdata);
        check($sformatf("v%0d setup_cycles", idx), 32'(setup_cnt),
              (v.exp_psel != 4'b0) ? 32'd1 : 32'd0);
        check($sformatf("v%0d access_cycles", idx), 32'(acc), 32'(v.exp_acc));
        check($sformatf("v%0d paddr_unstable", idx), 32'(paddr_bad), 32'd0);

        transfer = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ready || PSEL != 4'b0) trail++;
        end
        check($sformatf("v%0d trailing_activity", idx), 32'(trail), 32'd0);
    endtask

    initial begin
        //          we    addr           wdata          be       slv waits rdata_in      poke  psel     pstrb    err   exp_rdata      lat acc
        vecs[0]  = '{1'b1, 32'h1000_0004, 32'hA5A5_1234, 4'b0011, 0, 0,    32'h0,        1'b0, 4'b0001, 4'b0011, 1'b0, 32'h0000_0000, 3, 1};
        vecs[1]  = '{1'b0, 32'h1000_2010, 32'h1111_1111, 4'b1111, 2, 3,    32'h0000_00FF, 1'b0, 4'b0100, 4'b0000, 1'b0, 32'h0000_00FF, 6, 4};
        vecs[2]  = '{1'b0, 32'h2000_0000, 32'h2222_2222, 4'b1111, 0, 0,    32'h5555_5555, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 1, 0};
        vecs[3]  = '{1'b0, 32'h1000_1000, 32'h3333_3333, 4'b1111, 1, 1000, 32'h7777_7777, 1'b0, 4'b0010, 4'b0000, 1'b1, 32'hDEAD_BEEF, 6, 4};
        vecs[4]  = '{1'b1, 32'h1000_3008, 32'h1234_5678, 4'b1111, 3, 1,    32'h4444_4444, 1'b0, 4'b1000, 4'b1111, 1'b0, 32'hDEAD_BEEF, 4, 2};
        vecs[5]  = '{1'b0, 32'h1000_3FFC, 32'h0,         4'b0110, 3, 0,    32'hCAFE_F00D, 1'b0, 4'b1000, 4'b0000, 1'b0, 32'hCAFE_F00D, 3, 1};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1111, 0, 0,    32'h0,        1'b0, 4'b0000, 4'b1111, 1'b1, 32'hCAFE_F00D, 1, 0};
        vecs[7]  = '{1'b0, 32'h1000_0ABC, 32'h0,         4'b1111, 0, 2,    32'h1357_9BDF, 1'b0, 4'b0001, 4'b0000, 1'b0, 32'h1357_9BDF, 5, 3};
        vecs[8]  = '{1'b0, 32'h1000_4000, 32'h0,         4'b1111, 0, 0,    32'h6666_6666, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 1, 0};
        vecs[9]  = '{1'b1, 32'h1000_1040, 32'h0BAD_C0DE, 4'b0101, 1, 3,    32'h8888_8888, 1'b1, 4'b0010, 4'b0101, 1'b0, 32'h0000_0000, 6, 4};
        vecs[10] = '{1'b1, 32'h1000_2000, 32'h9999_9999, 4'b1000, 2, 1000, 32'h9999_0000, 1'b0, 4'b0100, 4'b1000, 1'b1, 32'h0000_0000, 6, 4};
        vecs[11] = '{1'b0, 32'h1000_3000, 32'h0,         4'b1111, 3, 0,    32'h7654_3210, 1'b0, 4'b1000, 4'b0000, 1'b0, 32'h7654_3210, 3, 1};

        reset = 1'b0; transfer = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0;
        Byte_Enable = '0; PRDATA = '0; PREADY = '0;
        repeat (2) @(negedge clk);
        check("reset ready", {31'b0, ready}, 32'd0);
        check("reset busErr", {31'b0, busErr}, 32'd0);
        check("reset busRData", busRData, 32'd0);
        check("reset PSEL/PENABLE", {27'b0, PSEL, PENABLE}, 32'd0);
        check("reset PADDR", PADDR, 32'd0);
        check("reset PWDATA/PSTRB/PWRITE", {PWDATA[26:0], PSTRB, PWRITE}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i);

        // Reset while a read to slave 3 is waiting in ACCESS.
        @(negedge clk);
        PREADY = 4'b0000; transfer = 1'b1; busWe = 1'b0; busAddr = 32'h1000_3000;
        @(negedge clk);
        transfer = 1'b0;
        @(negedge clk);
        check("pre-reset in ACCESS", {27'b0, PSEL, PENABLE}, {27'b0, 4'b1000, 1'b1});
        #2 reset = 1'b0;
        #1;
        check("async reset PSEL", {28'b0, PSEL}, 32'd0);
        check("async reset PENABLE/ready", {30'b0, PENABLE, ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post-reset quiet %0d", k), {27'b0, ready, PSEL}, 32'd0);
        end
        run_vec(11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
